// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; also imported by decode and the hazard unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one IMEM request in flight and fills
// a single IF/ID output slot, honouring STALL and flushing on REDIRECT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTR_OUT,
  output logic [31:0] COUNTER_OUT,
  output logic        VALID_OUT
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fpc_q, fpc_d;
  logic         drop_q, drop_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  counter_q, counter_d;
  logic         valid_q, valid_d;
  logic         imem_req;
  logic         consume;

  // Requesting only when the slot is empty or draining this edge means a
  // response can always be written without a skid buffer.
  assign consume  = valid_q && !STALL;
  assign imem_req = (state_q == REQ) && (!valid_q || !STALL);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fpc_d     = fpc_q;
    drop_d    = drop_q;
    instr_d   = instr_q;
    counter_d = counter_q;
    valid_d   = valid_q;

    if (consume) valid_d = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req && IMEM_GNT) begin
          fpc_d   = pc_q;
          pc_d    = pc_q + PC_STEP;
          state_d = WAIT;
          if (REDIRECT) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (IMEM_RVALID) begin
          state_d = REQ;
          drop_d  = 1'b0;
          if (!drop_q && !REDIRECT) begin
            instr_d   = IMEM_RDATA;
            counter_d = fpc_q + PC_STEP;
            valid_d   = 1'b1;
          end
        end else if (REDIRECT) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides both the sequential PC update and any slot fill above.
    if (REDIRECT && (state_q != IDLE)) begin
      pc_d    = REDIRECT_PC;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      fpc_q     <= RESET_PC;
      drop_q    <= 1'b0;
      instr_q   <= NOP_INSTR;
      counter_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fpc_q     <= fpc_d;
      drop_q    <= drop_d;
      instr_q   <= instr_d;
      counter_q <= counter_d;
      valid_q   <= valid_d;
    end
  end

  assign IMEM_REQ    = imem_req;
  assign IMEM_ADDR   = pc_q;
  assign INSTR_OUT   = instr_q;
  assign COUNTER_OUT = counter_q;
  assign VALID_OUT   = valid_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter and issues one instruction-memory request at a time.
- Drives the instruction word and sequential PC into the IF/ID pipeline register.
- Honours back-pressure (STALL) and branch/jump redirects from later stages, discarding wrong-path responses.
- Sits between instruction memory and the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential instructions.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- STALL  in  1  downstream cannot accept; hold the output slot.
- REDIRECT  in  1  take REDIRECT_PC; flush the slot and any in-flight response.
- REDIRECT_PC  in  32  redirect target.
- IMEM_REQ  out  1  memory request valid.
- IMEM_ADDR  out  32  request byte address.
- IMEM_GNT  in  1  memory accepted the request this cycle.
- IMEM_RVALID  in  1  read data valid; arrives at least 1 cycle after GNT.
- IMEM_RDATA  in  32  instruction word.
- INSTR_OUT  out  32  instruction to the IF/ID register.
- COUNTER_OUT  out  32  fetched address + PC_STEP.
- VALID_OUT  out  1  INSTR_OUT/COUNTER_OUT hold a valid, unconsumed instruction.

Behaviour:
- Reset (RESET_N low, async): PC=RESET_PC, state=IDLE, DROP=0, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR_OUT=0 (NOP), COUNTER_OUT=0, VALID_OUT=0.
- Reset mid-transaction abandons the outstanding request; an RVALID arriving in IDLE is ignored.
- Slot consumption: on an edge where VALID_OUT=1 and STALL=0, the slot is consumed and VALID_OUT clears unless refilled on the same edge.
- FSM, IDLE: lasts exactly one cycle after reset release, then goes to REQ.
- FSM, REQ:
  - IMEM_REQ=1 only when the slot is free (VALID_OUT=0) or is being consumed this cycle (STALL=0). Otherwise IMEM_REQ=0 and the FSM waits.
  - IMEM_ADDR=PC, combinational from PC.
  - On IMEM_REQ & IMEM_GNT: FPC<=PC, PC<=PC+PC_STEP (mod 2^32, wraps), go to WAIT.
  - This rule guarantees any response lands in an empty slot; no skid buffer.
- FSM, WAIT:
  - IMEM_REQ=0.
  - On RVALID with DROP=1: clear DROP, go to REQ, slot untouched.
  - On RVALID with DROP=0: INSTR_OUT<=RDATA, COUNTER_OUT<=FPC+PC_STEP, VALID_OUT<=1, go to REQ.
- REDIRECT (priority over STALL and normal flow), every state except IDLE:
  - PC<=REDIRECT_PC and VALID_OUT<=0.
  - INSTR_OUT/COUNTER_OUT keep their old values.
- REDIRECT in REQ without GNT: stay in REQ; the new address appears next cycle (address change before grant is legal).
- REDIRECT in REQ with GNT: the old-path request is in flight; FPC is don't-care. Set DROP, go to WAIT, PC=REDIRECT_PC.
- REDIRECT in WAIT without RVALID: set DROP.
- REDIRECT in WAIT with RVALID: discard the response, DROP stays 0, go to REQ.
- Only one request is ever outstanding.
- Best-case throughput: one instruction per 2 cycles (REQ + WAIT with 1-cycle memory).
- First VALID_OUT occurs no earlier than 3 cycles after reset release.
- STALL held: no new request issues, and the slot holds INSTR_OUT/COUNTER_OUT/VALID_OUT unchanged.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE, REQ, WAIT);
  - NOP_INSTR = 32'h0;
  - default RESET_PC and PC_STEP constants, shared with the decode stage and the hazard unit.
- No sub-module is natural: a single FSM plus PC/FPC/DROP/slot registers, in one module.

Test Plan:
- Reset release, 1-cycle-latency memory, STALL=0: IMEM_ADDR sequence 0x0, 0x4, 0x8. The first VALID_OUT carries INSTR_OUT=mem[0x0] and COUNTER_OUT=0x4; one instruction every 2 cycles.
- STALL high for 5 cycles while VALID_OUT=1 with COUNTER_OUT=0x8: outputs hold, IMEM_REQ=0 throughout. After STALL drops, the request to 0x8 issues in that same cycle.
- REDIRECT to 0x100 while in WAIT for 0xC: the response for 0xC is dropped (VALID_OUT stays 0). The next IMEM_ADDR is 0x100, and the delivered COUNTER_OUT is 0x104.
- REDIRECT and IMEM_GNT in the same REQ cycle (PC=0x20, target 0x40): the 0x20 response is discarded and the next request is 0x40.
- GNT withheld 3 cycles at PC=0xFFFF_FFFC: IMEM_ADDR stays stable. After the grant, PC wraps to 0x0 and COUNTER_OUT = 0x0.
- RESET_N pulsed low mid-WAIT: all outputs return to reset values asynchronously. A late RVALID is ignored, and fetching restarts at RESET_PC.
